calendar_set_ctrl: RTL and testbench

//  Sequencer for the calendar counters: day-of-week (1..7), date, month and year.
//  RUN mode: forwards the midnight tick as a one-cycle advance enable to the counters.
//  SET mode: a button FSM edits a shadow copy of the fields, then commits them with one

---
 rtl/calendar_set_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_calendar_set_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calendar_set_ctrl.sv
// Calendar sequencer: forwards the midnight tick in RUN mode and runs a button-driven
// edit session on a shadow copy of day/date/month/year, committed with a single load strobe.
module calendar_set_ctrl #(
  parameter int YEAR_MAX  = 99,
  parameter int DAY_FIRST = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_day,
  input  logic       btn_mode,
  input  logic       btn_next,
  input  logic       btn_inc,
  input  logic [2:0] cur_day,
  input  logic [4:0] cur_date,
  input  logic [3:0] cur_month,
  input  logic [6:0] cur_year,
  output logic       day_adv,
  output logic       ld_all,
  output logic [2:0] day_data,
  output logic [4:0] date_data,
  output logic [3:0] month_data,
  output logic [6:0] year_data,
  output logic       setting,
  output logic [1:0] field_sel
);

  localparam logic [2:0] S_RUN     = 3'd0;
  localparam logic [2:0] S_E_DAY   = 3'd1;
  localparam logic [2:0] S_E_DATE  = 3'd2;
  localparam logic [2:0] S_E_MONTH = 3'd3;
  localparam logic [2:0] S_E_YEAR  = 3'd4;
  localparam logic [2:0] S_COMMIT  = 3'd5;

  logic [2:0] state_reg, state_next;
  logic       mode_q_reg, next_q_reg, inc_q_reg;
  logic       pending_reg, pending_next;
  logic [2:0] sh_day_reg, sh_day_next;
  logic [4:0] sh_date_reg, sh_date_next;
  logic [3:0] sh_month_reg, sh_month_next;
  logic [6:0] sh_year_reg, sh_year_next;
  logic       day_adv_reg, day_adv_next;
  logic       ld_all_reg;
  logic       setting_reg;
  logic [1:0] field_sel_reg;
  logic [4:0] date_data_reg, date_data_next;

  logic mode_edge, next_edge, inc_edge;
  logic next_raw, inc_raw;

  // Days in a month; every year divisible by 4 is a leap year in the 2-digit range.
  function automatic logic [4:0] max_len(input logic [3:0] m, input logic [6:0] y);
    logic [4:0] r;
    case (m)
      4'd2:                      r = (y[1:0] == 2'b00) ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11:   r = 5'd30;
      default:                   r = 5'd31;
    endcase
    return r;
  endfunction

  function automatic logic is_edit(input logic [2:0] s);
    return (s == S_E_DAY) || (s == S_E_DATE) || (s == S_E_MONTH) || (s == S_E_YEAR);
  endfunction

  function automatic logic [1:0] field_of(input logic [2:0] s);
    logic [1:0] f;
    case (s)
      S_E_DATE:  f = 2'd1;
      S_E_MONTH: f = 2'd2;
      S_E_YEAR:  f = 2'd3;
      default:   f = 2'd0;
    endcase
    return f;
  endfunction

  // Priority mode > next > inc: a lower-priority edge in the same cycle is dropped.
  assign next_raw  = btn_next & ~next_q_reg;
  assign inc_raw   = btn_inc & ~inc_q_reg;
  assign mode_edge = btn_mode & ~mode_q_reg;
  assign next_edge = next_raw & ~mode_edge;
  assign inc_edge  = inc_raw & ~mode_edge & ~next_raw;

  always_comb begin
    state_next    = state_reg;
    pending_next  = pending_reg;
    sh_day_next   = sh_day_reg;
    sh_date_next  = sh_date_reg;
    sh_month_next = sh_month_reg;
    sh_year_next  = sh_year_reg;
    day_adv_next  = 1'b0;

    case (state_reg)
      S_RUN: begin
        day_adv_next = tick_day;
        pending_next = 1'b0;
        if (mode_edge) begin
          state_next    = S_E_DAY;
          sh_day_next   = cur_day;
          sh_date_next  = cur_date;
          sh_month_next = cur_month;
          sh_year_next  = cur_year;
        end
      end
      S_E_DAY, S_E_DATE, S_E_MONTH, S_E_YEAR: begin
        if (tick_day) pending_next = 1'b1;
        if (mode_edge) begin
          // Abort: a midnight missed while editing is replayed on the way out.
          state_next   = S_RUN;
          day_adv_next = pending_reg | tick_day;
          pending_next = 1'b0;
        end else if (next_edge) begin
          case (state_reg)
            S_E_DAY:   state_next = S_E_DATE;
            S_E_DATE:  state_next = S_E_MONTH;
            S_E_MONTH: state_next = S_E_YEAR;
            default:   state_next = S_COMMIT;
          endcase
        end else if (inc_edge) begin
          case (state_reg)
            S_E_DAY:
              sh_day_next = (sh_day_reg >= 3'd7) ? 3'(DAY_FIRST) : sh_day_reg + 3'd1;
            S_E_DATE:
              sh_date_next = (sh_date_reg >= max_len(sh_month_reg, sh_year_reg)) ?
                             5'd1 : sh_date_reg + 5'd1;
            S_E_MONTH:
              sh_month_next = (sh_month_reg >= 4'd12) ? 4'd1 : sh_month_reg + 4'd1;
            default:
              sh_year_next = (sh_year_reg >= 7'(YEAR_MAX)) ? 7'd0 : sh_year_reg + 7'd1;
          endcase
        end
      end
      S_COMMIT: begin
        state_next   = S_RUN;
        pending_next = 1'b0;
      end
      default: begin
        state_next   = S_RUN;
        pending_next = 1'b0;
      end
    endcase
  end

  // The committed date is clamped to the length of the edited month.
  always_comb begin
    date_data_next = sh_date_next;
    if (state_next == S_COMMIT) begin
      if (sh_date_next > max_len(sh_month_next, sh_year_next))
        date_data_next = max_len(sh_month_next, sh_year_next);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_RUN;
      mode_q_reg    <= 1'b0;
      next_q_reg    <= 1'b0;
      inc_q_reg     <= 1'b0;
      pending_reg   <= 1'b0;
      sh_day_reg    <= 3'd1;
      sh_date_reg   <= 5'd1;
      sh_month_reg  <= 4'd1;
      sh_year_reg   <= 7'd0;
      day_adv_reg   <= 1'b0;
      ld_all_reg    <= 1'b0;
      setting_reg   <= 1'b0;
      field_sel_reg <= 2'd0;
      date_data_reg <= 5'd1;
    end else begin
      state_reg     <= state_next;
      mode_q_reg    <= btn_mode;
      next_q_reg    <= btn_next;
      inc_q_reg     <= btn_inc;
      pending_reg   <= pending_next;
      sh_day_reg    <= sh_day_next;
      sh_date_reg   <= sh_date_next;
      sh_month_reg  <= sh_month_next;
      sh_year_reg   <= sh_year_next;
      day_adv_reg   <= day_adv_next;
      ld_all_reg    <= (state_next == S_COMMIT);
      setting_reg   <= is_edit(state_next);
      field_sel_reg <= field_of(state_next);
      date_data_reg <= date_data_next;
    end
  end

  assign day_adv    = day_adv_reg;
  assign ld_all     = ld_all_reg;
  assign setting    = setting_reg;
  assign field_sel  = field_sel_reg;
  assign day_data   = sh_day_reg;
  assign date_data  = date_data_reg;
  assign month_data = sh_month_reg;
  assign year_data  = sh_year_reg;

endmodule

// File: tb/tb_calendar_set_ctrl.sv
// Scoreboard bench for calendar_set_ctrl: stimulus queues expected day_adv / ld_all events,
// a negedge monitor pops and compares them whenever the DUT asserts either strobe.
module tb_calendar_set_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_day = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_next = 1'b0;
  logic       btn_inc = 1'b0;
  logic [2:0] cur_day = 3'd1;
  logic [4:0] cur_date = 5'd1;
  logic [3:0] cur_month = 4'd1;
  logic [6:0] cur_year = 7'd0;
  logic       day_adv;
  logic       ld_all;
  logic [2:0] day_data;
  logic [4:0] date_data;
  logic [3:0] month_data;
  logic [6:0] year_data;
  logic       setting;
  logic [1:0] field_sel;

  calendar_set_ctrl dut (
    .clk(clk), .rst_n(rst_n), .tick_day(tick_day),
    .btn_mode(btn_mode), .btn_next(btn_next), .btn_inc(btn_inc),
    .cur_day(cur_day), .cur_date(cur_date), .cur_month(cur_month), .cur_year(cur_year),
    .day_adv(day_adv), .ld_all(ld_all),
    .day_data(day_data), .date_data(date_data), .month_data(month_data), .year_data(year_data),
    .setting(setting), .field_sel(field_sel)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit   is_load;
    int   at_cyc;
    int   e_day;
    int   e_date;
    int   e_month;
    int   e_year;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic observe(input bit is_load);
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_%s: strobe with no queued expectation (cycle %0d)",
               is_load ? "ld_all" : "day_adv", cyc);
    end else begin
      e = sb_q.pop_front();
      chk("event_kind_is_load", int'(is_load), int'(e.is_load));
      chk("event_cycle", cyc, e.at_cyc);
      if (is_load) begin
        chk("day_data", int'(day_data), e.e_day);
        chk("date_data", int'(date_data), e.e_date);
        chk("month_data", int'(month_data), e.e_month);
        chk("year_data", int'(year_data), e.e_year);
        $display("txn load  cyc=%0d day=%0d date=%0d month=%0d year=%0d",
                 cyc, day_data, date_data, month_data, year_data);
      end else begin
        $display("txn adv   cyc=%0d", cyc);
      end
    end
  endtask

  // Monitor: decoupled from stimulus, samples on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (day_adv && ld_all) chk("adv_and_load_exclusive", 1, 0);
      if (day_adv) observe(1'b0);
      if (ld_all)  observe(1'b1);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // 0 = mode, 1 = next, 2 = inc; one rising edge then release.
  task automatic press(input int which);
    case (which)
      0: btn_mode = 1'b1;
      1: btn_next = 1'b1;
      default: btn_inc = 1'b1;
    endcase
    step(1);
    btn_mode = 1'b0;
    btn_next = 1'b0;
    btn_inc  = 1'b0;
    step(1);
  endtask

  task automatic expect_adv();
    exp_t e;
    e = '{is_load: 1'b0, at_cyc: cyc + 1, e_day: 0, e_date: 0, e_month: 0, e_year: 0};
    sb_q.push_back(e);
  endtask

  task automatic commit(input int d, input int dt, input int m, input int y);
    exp_t e;
    e = '{is_load: 1'b1, at_cyc: cyc + 1, e_day: d, e_date: dt, e_month: m, e_year: y};
    sb_q.push_back(e);
    press(1);
  endtask

  task automatic pulse_tick();
    tick_day = 1'b1;
    step(1);
    tick_day = 1'b0;
    step(1);
  endtask

  task automatic set_cur(input int d, input int dt, input int m, input int y);
    cur_day   = 3'(d);
    cur_date  = 5'(dt);
    cur_month = 4'(m);
    cur_year  = 7'(y);
  endtask

  initial begin
    step(3);
    rst_n = 1'b1;
    step(1);
    chk("reset_setting", int'(setting), 0);
    chk("reset_field_sel", int'(field_sel), 0);
    chk("reset_day_adv", int'(day_adv), 0);
    chk("reset_ld_all", int'(ld_all), 0);
    chk("reset_day_data", int'(day_data), 1);
    chk("reset_date_data", int'(date_data), 1);
    chk("reset_month_data", int'(month_data), 1);
    chk("reset_year_data", int'(year_data), 0);

    // Midnight tick in RUN: day_adv one cycle later, for one cycle.
    expect_adv();
    pulse_tick();
    step(3);

    // Day 6 -> 7 -> wraps to 1, committed after four next presses.
    set_cur(6, 15, 3, 30);
    press(0);
    chk("edit_setting", int'(setting), 1);
    chk("edit_field_day", int'(field_sel), 0);
    press(2);
    press(2);
    press(1);
    press(1);
    press(1);
    chk("edit_field_year", int'(field_sel), 3);
    commit(1, 15, 3, 30);
    step(1);
    chk("after_commit_setting", int'(setting), 0);

    // Date 31 clamped to Feb of leap year 24; a tick while editing is dropped on commit.
    set_cur(2, 31, 1, 23);
    press(0);
    press(1);
    press(1);
    press(2);
    pulse_tick();
    press(1);
    press(2);
    commit(2, 29, 2, 24);
    step(2);

    // Same, non-leap year 23.
    set_cur(2, 31, 1, 22);
    press(0);
    press(1);
    press(1);
    press(2);
    press(1);
    press(2);
    commit(2, 28, 2, 23);
    step(2);

    // Year 99 wraps to 0; date 31 clamped to 30 in April.
    set_cur(5, 31, 4, 99);
    press(0);
    press(1);
    press(1);
    press(1);
    press(2);
    commit(5, 30, 4, 0);
    step(2);

    // Tick during E_DATE then abort: no load, day_adv in the first RUN cycle.
    set_cur(4, 10, 5, 10);
    press(0);
    press(1);
    chk("edit_field_date", int'(field_sel), 1);
    pulse_tick();
    step(2);
    expect_adv();
    press(0);
    chk("abort_setting", int'(setting), 0);
    step(2);

    // Mode and inc edges in the same cycle in E_MONTH: abort wins, month untouched.
    set_cur(3, 12, 7, 40);
    press(0);
    press(1);
    press(1);
    chk("edit_field_month", int'(field_sel), 2);
    btn_mode = 1'b1;
    btn_inc  = 1'b1;
    step(1);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    step(1);
    chk("mode_inc_setting", int'(setting), 0);
    chk("mode_inc_month_kept", int'(month_data), 7);
    step(2);

    // Tick and mode edge together in RUN: day_adv still fires, edit begins.
    expect_adv();
    tick_day = 1'b1;
    btn_mode = 1'b1;
    step(1);
    tick_day = 1'b0;
    btn_mode = 1'b0;
    step(1);
    chk("tick_mode_setting", int'(setting), 1);
    press(0);
    chk("tick_mode_abort", int'(setting), 0);
    step(2);

    // inc held high for 10 cycles counts once.
    set_cur(3, 20, 6, 50);
    press(0);
    btn_inc = 1'b1;
    step(10);
    btn_inc = 1'b0;
    step(1);
    press(1);
    press(1);
    press(1);
    commit(4, 20, 6, 50);
    step(2);

    // Asynchronous reset in E_YEAR: immediate return to RUN, shadow back to reset values.
    set_cur(7, 9, 9, 9);
    press(0);
    press(1);
    press(1);
    press(1);
    chk("pre_reset_field", int'(field_sel), 3);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset_setting", int'(setting), 0);
    chk("async_reset_field_sel", int'(field_sel), 0);
    chk("async_reset_day_data", int'(day_data), 1);
    step(2);
    rst_n = 1'b1;
    step(4);
    chk("after_reset_setting", int'(setting), 0);

    chk("scoreboard_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
